// File: rtl/inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_queue
// Summary  : Circular byte queue between fetch and decode. Pushes one byte per
//            cycle, retires up to MAX_POP bytes per cycle, and supports
//            flushing on a taken branch.
// Revision : 1.0
// ============================================================================
module inst_prefetch_queue #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int MAX_POP  = 3,
   parameter int LOW_MARK = 3
) (
   input  logic                         queue_clk,
   input  logic                         queue_reset,
   input  logic                         queue_flush,
   input  logic [DATA_W-1:0]            queue_in,
   input  logic                         queue_push,
   output logic                         queue_full,
   output logic [MAX_POP*DATA_W-1:0]    queue_out,
   output logic [$clog2(DEPTH+1)-1:0]   queue_avail,
   input  logic                         queue_pop,
   input  logic [1:0]                   queue_pop_len,
   output logic                         queue_low,
   output logic                         queue_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int EXT_W = CNT_W + 1;

   logic [DATA_W-1:0] storage [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              err_q;

   logic              push_acc;
   logic              pop_len_ok;
   logic              pop_acc;
   logic              err_next;
   logic [EXT_W-1:0]  count_next;

   // Status flags depend only on the registered count.
   assign queue_full  = (count == CNT_W'(DEPTH));
   assign queue_avail = count;
   assign queue_low   = (count < CNT_W'(LOW_MARK));
   assign queue_err   = err_q;

   always_comb begin
      push_acc   = queue_push & ~queue_full;
      pop_len_ok = (queue_pop_len != 2'd0) &&
                   (queue_pop_len <= 2'(MAX_POP)) &&
                   (CNT_W'(queue_pop_len) <= count);
      pop_acc    = queue_pop & pop_len_ok;
      err_next   = (queue_push & queue_full) | (queue_pop & ~pop_len_ok);
      count_next = EXT_W'(count) + EXT_W'(push_acc)
                   - (pop_acc ? EXT_W'(queue_pop_len) : EXT_W'(0));
   end

   always_ff @(posedge queue_clk) begin
      if (queue_reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         err_q  <= 1'b0;
      end else if (queue_flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         err_q  <= 1'b0;
      end else begin
         if (push_acc) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_acc) begin
            rd_ptr <= rd_ptr + PTR_W'(queue_pop_len);
         end
         count <= CNT_W'(count_next);
         err_q <= err_next;
      end
   end

   // Storage is never cleared; stale bytes are masked out of the window by count.
   always_ff @(posedge queue_clk) begin
      if (!queue_reset && !queue_flush && push_acc) begin
         storage[wr_ptr] <= queue_in;
      end
   end

   for (genvar i = 0; i < MAX_POP; i++) begin : g_window
      localparam logic [PTR_W-1:0] OFFSET = PTR_W'(i);
      logic [PTR_W-1:0] slot;
      assign slot = rd_ptr + OFFSET;
      assign queue_out[i*DATA_W +: DATA_W] = (count > CNT_W'(i)) ? storage[slot] : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_prefetch_queue
// Summary  : Directed vector bench for inst_prefetch_queue.
// Revision : 1.0
// ============================================================================
module tb_inst_prefetch_queue;

   logic        clk = 1'b0;
   logic        q_reset = 1'b1;
   logic        q_flush = 1'b0;
   logic [7:0]  q_in = 8'h00;
   logic        q_push = 1'b0;
   logic        q_full;
   logic [23:0] q_out;
   logic [4:0]  q_avail;
   logic        q_pop = 1'b0;
   logic [1:0]  q_len = 2'd0;
   logic        q_low;
   logic        q_err;

   always #5 clk = ~clk;

   inst_prefetch_queue #(
      .DATA_W(8), .DEPTH(16), .MAX_POP(3), .LOW_MARK(3)
   ) dut (
      .queue_clk    (clk),
      .queue_reset  (q_reset),
      .queue_flush  (q_flush),
      .queue_in     (q_in),
      .queue_push   (q_push),
      .queue_full   (q_full),
      .queue_out    (q_out),
      .queue_avail  (q_avail),
      .queue_pop    (q_pop),
      .queue_pop_len(q_len),
      .queue_low    (q_low),
      .queue_err    (q_err)
   );

   typedef struct {
      logic        rst;
      logic        flush;
      logic        push;
      logic [7:0]  din;
      logic        pop;
      logic [1:0]  len;
      logic [4:0]  avail;
      logic        err;
      logic [23:0] out;
   } vec_t;

   vec_t vq[$];
   int   applied     = 0;
   int   miscompares = 0;

   task automatic add(input logic rst, input logic flush, input logic push,
                      input logic [7:0] din, input logic pop, input logic [1:0] len,
                      input logic [4:0] avail, input logic err, input logic [23:0] out);
      vec_t v;
      v.rst = rst; v.flush = flush; v.push = push; v.din = din;
      v.pop = pop; v.len = len; v.avail = avail; v.err = err; v.out = out;
      vq.push_back(v);
   endtask

   // Pushes n consecutive bytes base, base+1, ... into an empty queue.
   task automatic add_fill(input logic [7:0] base, input int n);
      logic [7:0]  b0, b1, b2;
      logic [23:0] w;
      b0 = base;
      b1 = base + 8'd1;
      b2 = base + 8'd2;
      for (int k = 0; k < n; k++) begin
         if (k == 0)      w = {16'h0000, b0};
         else if (k == 1) w = {8'h00, b1, b0};
         else             w = {b2, b1, b0};
         add(0, 0, 1, base + 8'(k), 0, 0, 5'(k + 1), 0, w);
      end
   endtask

   task automatic check(input string name, input logic [4:0] avail,
                        input logic err, input logic [23:0] out);
      logic full_e, low_e;
      full_e = (avail == 5'd16);
      low_e  = (avail < 5'd3);
      applied++;
      if (q_avail !== avail || q_full !== full_e || q_low !== low_e ||
          q_err !== err || q_out !== out) begin
         miscompares++;
         $display("FAIL %s: got avail=%0d full=%b low=%b err=%b out=%h, expected avail=%0d full=%b low=%b err=%b out=%h",
                  name, q_avail, q_full, q_low, q_err, q_out,
                  avail, full_e, low_e, err, out);
      end
   endtask

   task automatic step(input logic rst, input logic flush, input logic push,
                       input logic [7:0] din, input logic pop, input logic [1:0] len);
      q_reset = rst; q_flush = flush; q_push = push;
      q_in = din; q_pop = pop; q_len = len;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset and basic three-byte push
      add(1, 0, 0, 8'h00, 0, 0, 0, 0, 24'h0);
      add(0, 0, 1, 8'hA9, 0, 0, 1, 0, 24'h0000A9);
      add(0, 0, 1, 8'h05, 0, 0, 2, 0, 24'h0005A9);
      add(0, 0, 1, 8'h8D, 0, 0, 3, 0, 24'h8D05A9);
      add(0, 1, 0, 8'h00, 0, 0, 0, 0, 24'h0);

      // Fill to full, reject overflow, pop 3, refill, push-at-full with pop
      add_fill(8'h00, 16);
      add(0, 0, 1, 8'hFF, 0, 0, 16, 1, 24'h020100);
      add(0, 0, 0, 8'h00, 1, 3, 13, 0, 24'h050403);
      add(0, 0, 1, 8'h10, 0, 0, 14, 0, 24'h050403);
      add(0, 0, 1, 8'h11, 0, 0, 15, 0, 24'h050403);
      add(0, 0, 1, 8'h12, 0, 0, 16, 0, 24'h050403);
      add(0, 0, 1, 8'hEE, 1, 1, 15, 1, 24'h060504);
      add(0, 1, 0, 8'h00, 0, 0, 0, 0, 24'h0);

      // Illegal pop lengths
      add(0, 0, 1, 8'h21, 0, 0, 1, 0, 24'h000021);
      add(0, 0, 1, 8'h22, 0, 0, 2, 0, 24'h002221);
      add(0, 0, 0, 8'h00, 1, 3, 2, 1, 24'h002221);
      add(0, 0, 0, 8'h00, 0, 0, 2, 0, 24'h002221);
      add(0, 0, 0, 8'h00, 1, 0, 2, 1, 24'h002221);
      add(0, 0, 0, 8'h00, 1, 2, 0, 0, 24'h0);
      add(0, 0, 1, 8'h30, 1, 0, 1, 1, 24'h000030);
      add(0, 0, 0, 8'h00, 1, 1, 0, 0, 24'h0);

      // Pointer wrap-around
      add(0, 0, 1, 8'h7E, 0, 0, 1, 0, 24'h00007E);
      add(0, 0, 1, 8'h7F, 0, 0, 2, 0, 24'h007F7E);
      add(0, 0, 0, 8'h00, 1, 2, 0, 0, 24'h0);
      add(0, 0, 1, 8'h80, 0, 0, 1, 0, 24'h000080);
      for (int k = 0; k < 40; k++) begin
         add(0, 0, 1, 8'h81 + 8'(k), 1, 1, 1, 0, {16'h0000, 8'h81 + 8'(k)});
      end
      add(0, 0, 0, 8'h00, 1, 1, 0, 0, 24'h0);
      add(0, 0, 1, 8'h11, 0, 0, 1, 0, 24'h000011);
      add(0, 0, 1, 8'h22, 0, 0, 2, 0, 24'h002211);
      add(0, 0, 1, 8'h33, 0, 0, 3, 0, 24'h332211);
      add(0, 0, 0, 8'h00, 1, 3, 0, 0, 24'h0);

      // Simultaneous push and pop
      add_fill(8'h41, 5);
      add(0, 0, 1, 8'h44, 1, 2, 4, 0, 24'h454443);
      add(0, 0, 0, 8'h00, 1, 3, 1, 0, 24'h000044);
      add(0, 0, 0, 8'h00, 1, 1, 0, 0, 24'h0);

      // Flush beats push; flush suppresses err
      add_fill(8'h61, 7);
      add(0, 1, 1, 8'h55, 0, 0, 0, 0, 24'h0);
      add(0, 0, 0, 8'h00, 0, 0, 0, 0, 24'h0);
      add(0, 1, 0, 8'h00, 1, 0, 0, 0, 24'h0);

      // Reset beats push/pop, clears err, first push after reset accepted
      add_fill(8'h71, 9);
      add(1, 0, 1, 8'hAA, 1, 2, 0, 0, 24'h0);
      add(0, 0, 0, 8'h00, 1, 0, 0, 1, 24'h0);
      add(1, 0, 0, 8'h00, 1, 3, 0, 0, 24'h0);
      add(0, 0, 1, 8'hBB, 0, 0, 1, 0, 24'h0000BB);

      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].rst, vq[i].flush, vq[i].push, vq[i].din, vq[i].pop, vq[i].len);
         check($sformatf("vec%0d", i), vq[i].avail, vq[i].err, vq[i].out);
      end

      // Error pulse lasts exactly one cycle, then the queue drains normally
      step(0, 0, 0, 8'h00, 1, 3);
      check("err_pulse_on", 1, 1, 24'h0000BB);
      step(0, 0, 0, 8'h00, 0, 0);
      check("err_pulse_off", 1, 0, 24'h0000BB);
      step(0, 0, 0, 8'h00, 1, 1);
      check("drain_last", 0, 0, 24'h0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
